// File: rtl/attn_pkg.sv
// Shared Q-format constants, FSM encoding and width helpers for the attention datapath.
package attn_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned FRAC  = 6;
    localparam int unsigned Q_ONE = 64;

    typedef enum logic [1:0] {FILL, DIV, DRAIN} state_t;

    function automatic int unsigned sum_width(input int unsigned dw, input int unsigned row_len_max);
        return dw + $clog2(row_len_max);
    endfunction

    function automatic int unsigned quot_width(input int unsigned frac, input int unsigned sumw);
        return frac + sumw + 1;
    endfunction

endpackage

// File: rtl/recip_div.sv
// Bit-serial restoring divider computing floor(2^SHIFT / den), one quotient bit per cycle.
module recip_div #(
    parameter int unsigned SHIFT = 18,
    parameter int unsigned DENW  = 12,
    parameter int unsigned QW    = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [DENW-1:0] den,
    output logic            busy,
    output logic            done,
    output logic [QW-1:0]   quot
);
    localparam int unsigned CNTW = $clog2(QW + 1);

    logic [DENW-1:0] den_q;
    logic [DENW-1:0] rem;
    logic [CNTW-1:0] left;
    logic [DENW:0]   rem_sh;
    logic [DENW:0]   diff;
    logic            ge;

    // quot starts as the dividend and shifts quotient bits in as dividend bits shift out
    assign rem_sh = {rem, quot[QW-1]};
    assign ge     = rem_sh >= {1'b0, den_q};
    assign diff   = rem_sh - {1'b0, den_q};
    assign done   = busy && (left == CNTW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            left  <= '0;
            den_q <= '0;
            rem   <= '0;
            quot  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            left  <= CNTW'(QW);
            den_q <= den;
            rem   <= '0;
            quot  <= QW'(1) << SHIFT;
        end else if (busy) begin
            rem  <= ge ? diff[DENW-1:0] : rem_sh[DENW-1:0];
            quot <= {quot[QW-2:0], ge};
            left <= left - CNTW'(1);
            if (left == CNTW'(1)) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/softmax_norm.sv
// Softmax normalizer: buffers and sums one row of Q1.6 exponents, divides once, streams p_i = e_i / sum.
module softmax_norm #(
    parameter int unsigned ROW_LEN_MAX = 16,
    parameter int unsigned DW          = attn_pkg::DW,
    parameter int unsigned FRAC        = attn_pkg::FRAC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          err_overflow
);
    import attn_pkg::*;

    localparam int unsigned SUMW = sum_width(DW, ROW_LEN_MAX);
    localparam int unsigned QW   = quot_width(FRAC, SUMW);
    localparam int unsigned CW   = $clog2(ROW_LEN_MAX);
    localparam int unsigned LW   = CW + 1;
    localparam int unsigned PW   = DW + QW;
    localparam logic [PW-1:0] ROUND = PW'(1) << (SUMW - 1);
    localparam logic [DW-1:0] ONE   = DW'(1) << FRAC;

    state_t          state, state_nx;
    logic [DW-1:0]   row_buf [ROW_LEN_MAX];
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   idx;
    logic [LW-1:0]   len;
    logic [SUMW-1:0] sum;
    logic [SUMW-1:0] sum_nx;
    logic            zero_row;
    logic            in_hs, out_hs, at_max, row_end, forced;
    logic            div_start, div_busy, div_done;
    logic [QW-1:0]   quot, recip;
    logic [PW-1:0]   prod, scaled;

    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign at_max    = (cnt == CW'(ROW_LEN_MAX - 1));
    assign row_end   = in_hs && (in_last || at_max);
    assign forced    = in_hs && !in_last && at_max;
    assign sum_nx    = sum + SUMW'(in_data);
    assign div_start = row_end && (sum_nx != '0);

    recip_div #(
        .SHIFT (FRAC + SUMW),
        .DENW  (SUMW),
        .QW    (QW)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .den   (sum_nx),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nx;
    end

    // An all-zero row still spends one cycle in DIV so its output starts one cycle after row end
    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (row_end) state_nx = DIV;
            DIV:     if (zero_row || div_done) state_nx = DRAIN;
            DRAIN:   if (out_hs && out_last) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state == FILL) && !div_busy;
        out_valid = (state == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (in_hs) row_buf[cnt] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            idx          <= '0;
            len          <= '0;
            sum          <= '0;
            zero_row     <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_overflow <= forced;
            if (in_hs) begin
                cnt <= cnt + CW'(1);
                sum <= sum_nx;
            end
            if (row_end) begin
                len      <= {1'b0, cnt} + LW'(1);
                zero_row <= (sum_nx == '0);
            end
            if (out_hs) begin
                if (out_last) begin
                    idx <= '0;
                    cnt <= '0;
                    sum <= '0;
                end else begin
                    idx <= idx + CW'(1);
                end
            end
        end
    end

    assign recip    = zero_row ? '0 : quot;
    assign prod     = PW'(row_buf[idx]) * PW'(recip);
    assign scaled   = (prod + ROUND) >> SUMW;
    assign out_data = !out_valid ? '0 : (scaled > PW'(ONE)) ? ONE : scaled[DW-1:0];
    assign out_last = out_valid && ({1'b0, idx} == len - LW'(1));

endmodule

// File: tb/tb_softmax_norm.sv
// Scoreboard bench for softmax_norm: row model, output data/last/latency checks, stalls and mid-row reset.
module tb_softmax_norm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       err_overflow;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc_q[$];
    int unsigned row[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned ovf_seen = 0;
    bit          stall = 1'b0;

    softmax_norm #(
        .ROW_LEN_MAX (16),
        .DW          (8),
        .FRAC        (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at t=%0t", tag, got, want, $time);
        end
    endtask

    // Drives the global row; model: R = floor(2^18/sum), p = min(64, (e*R + 2048) >> 12)
    task automatic send_row(input bit use_last, input bit score);
        int unsigned n, sum, r, v, lat, waited;
        bit          rdy, accepted;
        exp_t        e;
        n = (row.size() > 16) ? 16 : row.size();
        sum = 0;
        for (int i = 0; i < int'(n); i++) sum += row[i];
        r = (sum == 0) ? 0 : (32'd1 << 18) / sum;
        lat = (sum == 0) ? 1 : 19;
        if (score) begin
            for (int i = 0; i < int'(n); i++) begin
                v = (row[i] * r + 2048) >> 12;
                e.data = 8'((v > 64) ? 64 : v);
                e.last = (i == int'(n) - 1);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < int'(n); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(row[i]);
            in_last  = use_last && (i == int'(n) - 1);
            accepted = 1'b0;
            waited   = 0;
            while (!accepted) begin
                #1;
                rdy = in_ready;
                @(posedge clk);
                if (rdy) begin
                    accepted = 1'b1;
                end else begin
                    waited++;
                    if (waited > 200) begin
                        check("in_ready_timeout", 32'(in_ready), 32'd1);
                        in_valid = 1'b0;
                        return;
                    end
                    @(negedge clk);
                end
            end
            #1;
            check("err_overflow", 32'(err_overflow), 32'(!use_last && i == 15));
        end
        if (score) cyc_q.push_back(cyc + lat);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial forever begin
        @(negedge clk);
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin : monitor
        bit in_row;
        in_row = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                in_row = 1'b0;
            end else begin
                if (err_overflow) ovf_seen++;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexp_out", 32'(out_valid), 32'd0);
                    end else begin
                        check("out_data", 32'(out_data), 32'(exp_q[0].data));
                        check("out_last", 32'(out_last), 32'(exp_q[0].last));
                        if (!in_row) begin
                            in_row = 1'b1;
                            if (cyc_q.size() != 0) check("latency", cyc, cyc_q.pop_front());
                        end
                        if (out_ready) begin
                            if (exp_q[0].last) in_row = 1'b0;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        int unsigned guard;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err", 32'(err_overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        row = {64, 64};        send_row(1'b1, 1'b1);
        row = {127};           send_row(1'b1, 1'b1);
        row = {64, 32, 32};    send_row(1'b1, 1'b1);
        row = {3, 125};        send_row(1'b1, 1'b1);
        row = {0, 0, 0};       send_row(1'b1, 1'b1);
        row = {};
        for (int i = 0; i < 16; i++) row.push_back(10);
        send_row(1'b0, 1'b1);
        row = {};
        for (int i = 0; i < 16; i++) row.push_back(4 + i);
        send_row(1'b1, 1'b1);

        stall = 1'b1;
        row = {200, 10, 30, 90, 5}; send_row(1'b1, 1'b1);
        row = {17, 33, 1, 255};     send_row(1'b1, 1'b1);

        // row abandoned by reset while the divider is running
        row = {50, 60};             send_row(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        row = {20, 40, 60, 80};     send_row(1'b1, 1'b1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        check("ovf_pulses", ovf_seen, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/softmax_norm.md
# softmax_norm

Softmax normalizer at the consumer end of the exponent stage. It accepts one row of unsigned Q1.6 exponent values over a valid/ready stream and buffers the row while summing it. A sequential restoring divider then computes one reciprocal per row. The block streams out normalized Q1.6 probabilities, p_i = e_i / Σe, to the attention-weight path.

## Interface
- ROW_LEN_MAX, 16: max beats per row; power of two, ≥2.
- DW, 8: input/output data width.
- FRAC, 6: fractional bits (Q1.6, 1.0 = 64).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  DW  exponent value, unsigned Q1.6.
- in_last  in  1  final beat of row.
- out_valid  out  1  probability beat valid.
- out_ready  in  1  downstream accepts a beat.
- out_data  out  DW  probability, unsigned Q1.6, range 0..64.
- out_last  out  1  final beat of row.
- err_overflow  out  1  one-cycle pulse when a row is truncated at ROW_LEN_MAX.

## Operation
- Derived widths:
  - SUMW = DW + clog2(ROW_LEN_MAX), which is 12.
  - QW = FRAC + SUMW + 1, which is 19.
- FSM states FILL → DIV → DRAIN → FILL. Reset enters FILL.
- **FILL**
  - in_ready = 1.
  - Each handshake writes buf[cnt] = in_data, adds it to sum (SUMW bits, no overflow possible), and increments cnt.
  - A row ends on a handshake with in_last = 1.
  - A row also ends when the handshake lands at cnt == ROW_LEN_MAX−1 with in_last = 0. That case is a forced last and raises err_overflow for 1 cycle.
  - At row end, len = cnt+1. If sum ≠ 0, go to DIV. If sum == 0, set R = 0 and go to DRAIN.
- **DIV**
  - in_ready = 0.
  - Restoring division R = floor(2^(FRAC+SUMW) / sum), QW-bit quotient, one bit per cycle, QW cycles.
  - Go to DRAIN after the last iteration.
- **DRAIN**
  - in_ready = 0, out_valid = 1, idx starts at 0.
  - out_data = min(64, (buf[idx]·R + 2^(SUMW−1)) >> SUMW). The product is DW+QW bits, unsigned.
  - out_last = (idx == len−1).
  - Each out handshake increments idx.
  - The handshake with out_last = 1 clears cnt and sum and returns to FILL.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable.

## Timing
- Reset values:
  - Outputs: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, err_overflow = 0.
  - Internal: cnt = 0, sum = 0, idx = 0.
- Row end accepted at edge k:
  - sum ≠ 0: out_valid is first high after edge k+QW (k+19 by default).
  - sum == 0: out_valid is first high after edge k+1.
- Drain throughput: 1 beat/cycle with out_ready held high.
- in_ready falls after the row-end edge. Input beats presented during DIV/DRAIN are not accepted and must be held by the upstream.
- A new row's first beat can be accepted on the cycle after the out_last handshake. There is no overlap between rows.
- in_last on the ROW_LEN_MAX−1 beat is a normal last and does not raise err_overflow.
- Reset mid-row or mid-DIV/DRAIN discards the row immediately. State returns to FILL with all counters and outputs at reset values.
- All outputs are driven from registers, or combinationally from registered buf/R/idx only. There are no input→output combinational paths.

## Structure
- Shared package attn_pkg:
  - Q-format constants: FRAC, Q_ONE = 64, DW.
  - FSM state enum {FILL, DIV, DRAIN}.
  - SUMW/QW helper functions.
- Sub-module recip_div:
  - Sequential restoring divider with start/busy/done.
  - Parameterized dividend shift and widths.
  - Reusable for the later layer-norm block.
- Row buffer is a plain register array; no RAM macro.

## Test plan
- Row [64, 64]:
  - sum 128, R = 2048.
  - Outputs 32, 32; out_last on the second beat.
  - First out_valid 19 cycles after the last input handshake.
- Row [127]: sum 127, R = 2064 → output 64 with out_last = 1.
- Row [64, 32, 32]: outputs 32, 16, 16. Then row [3, 125] immediately after gives outputs 2, 63.
- Row [0, 0, 0]:
  - No DIV; outputs 0, 0, 0.
  - out_valid one cycle after the row-end handshake.
- 16 beats of 10 with in_last never set:
  - err_overflow pulses once on beat 16.
  - 16 outputs of 4 (R = 1638), out_last on beat 16.
- Random out_ready stalls during DRAIN plus rst_n pulsed mid-DIV:
  - out_data/out_last stable under stall.
  - After reset, in_ready = 1, out_valid = 0, and the next row produces correct results.
